// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control-bit, opcode and state definitions for the CPU sequencer
package cpu_ctrl_pkg;

   localparam int CW_W = 32;
   localparam int OP_W = 8;

   localparam int C0  = 0;
   localparam int C1  = 1;
   localparam int C2  = 2;
   localparam int C3  = 3;
   localparam int C4  = 4;
   localparam int C5  = 5;
   localparam int C6  = 6;
   localparam int C7  = 7;
   localparam int C8  = 8;
   localparam int C9  = 9;
   localparam int C10 = 10;
   localparam int C11 = 11;
   localparam int C12 = 12;
   localparam int C13 = 13;
   localparam int C14 = 14;
   localparam int C15 = 15;
   localparam int C16 = 16;
   localparam int C17 = 17;
   localparam int C18 = 18;
   localparam int C19 = 19;
   localparam int C20 = 20;
   localparam int C21 = 21;

   localparam logic [OP_W-1:0] OP_STORE  = 8'h01;
   localparam logic [OP_W-1:0] OP_LOAD   = 8'h02;
   localparam logic [OP_W-1:0] OP_ADD    = 8'h03;
   localparam logic [OP_W-1:0] OP_SUB    = 8'h04;
   localparam logic [OP_W-1:0] OP_JMPGEZ = 8'h05;
   localparam logic [OP_W-1:0] OP_JMP    = 8'h06;
   localparam logic [OP_W-1:0] OP_HALT   = 8'h07;
   localparam logic [OP_W-1:0] OP_MPY    = 8'h08;
   localparam logic [OP_W-1:0] OP_AND    = 8'h0A;
   localparam logic [OP_W-1:0] OP_OR     = 8'h0B;
   localparam logic [OP_W-1:0] OP_NOT    = 8'h0C;
   localparam logic [OP_W-1:0] OP_SHR    = 8'h0D;
   localparam logic [OP_W-1:0] OP_SHL    = 8'h0E;

   typedef enum logic [3:0] {
      S_IDLE,
      S_F0,
      S_F1,
      S_F2,
      S_DECODE,
      S_E0,
      S_E1,
      S_E2,
      S_HALTED
   } ctrl_state_t;

   function automatic logic [CW_W-1:0] cbit(input int idx);
      return CW_W'(1) << idx;
   endfunction

   // Number of execute steps after DECODE; HALT and NOPs have none.
   function automatic logic [1:0] exec_len(input logic [OP_W-1:0] op);
      case (op)
         OP_STORE, OP_LOAD, OP_ADD, OP_SUB,
         OP_MPY, OP_AND, OP_OR:        return 2'd3;
         OP_JMPGEZ, OP_JMP:            return 2'd2;
         OP_NOT, OP_SHR, OP_SHL:       return 2'd1;
         default:                      return 2'd0;
      endcase
   endfunction

   function automatic logic [CW_W-1:0] exec_word(input logic [OP_W-1:0] op,
                                                 input logic [1:0] step);
      logic [CW_W-1:0] w;
      w = '0;
      case (op)
         OP_STORE: begin
            case (step)
               2'd0:    w = cbit(C11);
               2'd1:    w = cbit(C12);
               2'd2:    w = cbit(C20);
               default: w = '0;
            endcase
         end
         OP_LOAD, OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR: begin
            // Operand fetch is common; only the final ALU step differs.
            if (step == 2'd0)      w = cbit(C5);
            else if (step == 2'd1) w = cbit(C6);
            else if (step == 2'd2) begin
               case (op)
                  OP_LOAD: w = cbit(C7);
                  OP_ADD:  w = cbit(C9);
                  OP_SUB:  w = cbit(C10);
                  OP_MPY:  w = cbit(C13);
                  OP_AND:  w = cbit(C14);
                  default: w = cbit(C16);
               endcase
            end
         end
         OP_JMPGEZ, OP_JMP: begin
            if (step == 2'd0)      w = cbit(C3);
            else if (step == 2'd1) w = cbit(C21);
         end
         OP_NOT: if (step == 2'd0) w = cbit(C17);
         OP_SHR: if (step == 2'd0) w = cbit(C18);
         OP_SHL: if (step == 2'd0) w = cbit(C19);
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational next-state and next-control-word logic
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  ctrl_state_t       state,
   input  logic              run,
   input  logic [OP_W-1:0]   opcode,
   input  logic              acc_neg,
   output ctrl_state_t       next_state,
   output logic [CW_W-1:0]   next_word
);

   logic [1:0] len;
   assign len = exec_len(opcode);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (run) next_state = S_F0;
         S_F0:     next_state = S_F1;
         S_F1:     next_state = S_F2;
         S_F2:     next_state = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_HALT)
               next_state = S_HALTED;
            else if (len == 2'd0 || (opcode == OP_JMPGEZ && acc_neg))
               next_state = S_F0;
            else
               next_state = S_E0;
         end
         S_E0:     next_state = (len > 2'd1) ? S_E1 : S_F0;
         S_E1:     next_state = (len > 2'd2) ? S_E2 : S_F0;
         S_E2:     next_state = S_F0;
         S_HALTED: next_state = S_HALTED;
         default:  next_state = S_IDLE;
      endcase
   end

   // The word is registered alongside the state, so it is chosen for the state being entered.
   always_comb begin
      next_word = '0;
      case (next_state)
         S_F0:    next_word = cbit(C0) | cbit(C2);
         S_F1:    next_word = cbit(C5);
         S_F2:    next_word = cbit(C4) | cbit(C8);
         S_E0:    next_word = exec_word(opcode, 2'd0);
         S_E1:    next_word = exec_word(opcode, 2'd1);
         S_E2:    next_word = exec_word(opcode, 2'd2);
         default: next_word = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - microprogrammed fetch/decode/execute sequencer for the accumulator CPU
module control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int CW_WIDTH = 32,
   parameter int OP_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [OP_WIDTH-1:0] opcode,
   input  logic                acc_neg,
   output logic [CW_WIDTH-1:0] control_signal,
   output logic                instr_done,
   output logic                halted
);

   ctrl_state_t     state;
   ctrl_state_t     next_state;
   logic [OP_W-1:0] op_q;
   logic [OP_W-1:0] eff_op;
   logic [CW_W-1:0] next_word;

   // The IR is only trusted in DECODE; execute steps replay the latched copy.
   assign eff_op = (state == S_DECODE) ? OP_W'(opcode) : op_q;

   ctrl_decode u_decode (
      .state      (state),
      .run        (run),
      .opcode     (eff_op),
      .acc_neg    (acc_neg),
      .next_state (next_state),
      .next_word  (next_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         control_signal <= '0;
         op_q           <= '0;
      end else begin
         state          <= next_state;
         control_signal <= CW_WIDTH'(next_word);
         if (state == S_DECODE)
            op_q <= eff_op;
      end
   end

   // Last step of an instruction is any step that hands back to F0 (IDLE start excluded).
   assign instr_done = !rst && (state != S_IDLE) && (next_state == S_F0);
   assign halted     = (state == S_HALTED);

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - table-driven self-checking bench for control_unit
module tb_control_unit;
   import cpu_ctrl_pkg::*;

   logic        clk;
   logic        rst;
   logic        run;
   logic [7:0]  opcode;
   logic        acc_neg;
   logic [31:0] control_signal;
   logic        instr_done;
   logic        halted;

   control_unit #(.CW_WIDTH(32), .OP_WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .opcode         (opcode),
      .acc_neg        (acc_neg),
      .control_signal (control_signal),
      .instr_done     (instr_done),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        run;
      logic [7:0]  op;
      logic        neg;
      logic [31:0] cs;
      logic        done;
      logic        halt;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   strobes  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [7:0] op, input logic n,
                      input logic [31:0] cs, input logic d, input logic h);
      vec_t v;
      v.run = r; v.op = op; v.neg = n; v.cs = cs; v.done = d; v.halt = h;
      vecs.push_back(v);
   endtask

   // Junk opcode/acc_neg outside DECODE must be ignored.
   task automatic add_fetch();
      add(1'b0, 8'h07, 1'b1, 32'h0000_0005, 1'b0, 1'b0);
      add(1'b1, 8'h07, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
      add(1'b0, 8'h07, 1'b1, 32'h0000_0110, 1'b0, 1'b0);
   endtask

   task automatic add_instr(input logic [7:0] op, input logic n, input int len,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
      add_fetch();
      add(1'b0, op, n, 32'h0, len == 0, 1'b0);
      if (len > 0) add(1'b0, 8'h07, 1'b1, w0, len == 1, 1'b0);
      if (len > 1) add(1'b0, 8'h07, 1'b0, w1, len == 2, 1'b0);
      if (len > 2) add(1'b0, 8'h07, 1'b1, w2, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; opcode = 8'h00; acc_neg = 1'b0;

      add(1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
      add(1'b1, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0);
      add_instr(8'h00,     1'b0, 0, 32'h0,        32'h0,        32'h0);
      add_instr(OP_ADD,    1'b0, 3, 32'h0000_0020, 32'h0000_0040, 32'h0000_0200);
      add_instr(OP_STORE,  1'b0, 3, 32'h0000_0800, 32'h0000_1000, 32'h0010_0000);
      add_instr(OP_JMPGEZ, 1'b0, 2, 32'h0000_0008, 32'h0020_0000, 32'h0);
      add_instr(OP_JMPGEZ, 1'b1, 0, 32'h0,        32'h0,        32'h0);
      add_instr(OP_JMP,    1'b1, 2, 32'h0000_0008, 32'h0020_0000, 32'h0);
      add_instr(OP_LOAD,   1'b0, 3, 32'h0000_0020, 32'h0000_0040, 32'h0000_0080);
      add_instr(OP_SUB,    1'b0, 3, 32'h0000_0020, 32'h0000_0040, 32'h0000_0400);
      add_instr(OP_MPY,    1'b0, 3, 32'h0000_0020, 32'h0000_0040, 32'h0000_2000);
      add_instr(OP_AND,    1'b0, 3, 32'h0000_0020, 32'h0000_0040, 32'h0000_4000);
      add_instr(OP_OR,     1'b0, 3, 32'h0000_0020, 32'h0000_0040, 32'h0001_0000);
      add_instr(OP_NOT,    1'b0, 1, 32'h0002_0000, 32'h0,        32'h0);
      add_instr(OP_SHR,    1'b0, 1, 32'h0004_0000, 32'h0,        32'h0);
      add_instr(OP_SHL,    1'b0, 1, 32'h0008_0000, 32'h0,        32'h0);
      add_instr(8'h09,     1'b0, 0, 32'h0,        32'h0,        32'h0);
      add_instr(8'hFF,     1'b1, 0, 32'h0,        32'h0,        32'h0);
      add_fetch();
      add(1'b0, OP_HALT, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         add(1'(i % 2), 8'(i), 1'(i % 3 == 0), 32'h0, 1'b0, 1'b1);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("reset cs", control_signal, 32'h0);
      chk("reset done", 32'(instr_done), 32'h0);
      chk("reset halted", 32'(halted), 32'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         run = vecs[i].run; opcode = vecs[i].op; acc_neg = vecs[i].neg;
         #1;
         chk($sformatf("vec%0d cs", i), control_signal, vecs[i].cs);
         chk($sformatf("vec%0d done", i), 32'(instr_done), 32'(vecs[i].done));
         chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].halt));
         if (control_signal[20]) strobes++;
      end
      chk("store strobe count", 32'(strobes), 32'd1);

      // Reset leaves HALTED and returns to IDLE
      @(negedge clk); rst = 1'b1; run = 1'b1; opcode = 8'h00; acc_neg = 1'b0;
      @(negedge clk); #1;
      chk("halt reset cs", control_signal, 32'h0);
      chk("halt reset halted", 32'(halted), 32'h0);
      rst = 1'b0; run = 1'b0;
      @(negedge clk); #1;
      chk("idle after reset cs", control_signal, 32'h0);
      run = 1'b1;
      @(negedge clk); #1;
      chk("restart F0", control_signal, 32'h0000_0005);
      run = 1'b0;
      @(negedge clk); #1;
      chk("restart F1", control_signal, 32'h0000_0020);
      @(negedge clk); #1;
      chk("restart F2", control_signal, 32'h0000_0110);
      @(negedge clk); opcode = OP_STORE; #1;
      chk("store decode", control_signal, 32'h0);
      @(negedge clk); opcode = 8'h00; #1;
      chk("store E0", control_signal, 32'h0000_0800);
      @(negedge clk); #1;
      chk("store E1", control_signal, 32'h0000_1000);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("abort cs", control_signal, 32'h0);
      chk("abort done", 32'(instr_done), 32'h0);
      chk("abort halted", 32'(halted), 32'h0);
      rst = 1'b0;
      strobes = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk($sformatf("post-abort idle %0d", i), control_signal, 32'h0);
         if (control_signal[20]) strobes++;
      end
      chk("aborted store strobe count", 32'(strobes), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
